// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_t : arbiter FSM states. Encoded in 3 bits so that corrupted
//                 encodings exist and can be detected and recovered from.
//   owner_t     : which requester owns the transaction (fetch or data side).
//   ERR_*       : bit positions inside the sticky error vector.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DS = 1'b1
  } owner_t;

  localparam int ERR_DS_MISALIGN = 0;
  localparam int ERR_IF_MISALIGN = 1;
  localparam int ERR_FSM         = 2;
  localparam int ERR_W           = 3;

  // True when a byte address is not word aligned.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_pick_v1.sv
// -----------------------------------------------------------------------------
// mem_arb_pick_v1
// Combinational winner selection between fetch (IF) and data (DS) requests.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin on a tie, the side not served last wins.
//   undefined : fixed priority, DS wins every tie (IF may starve).
// Ports:
//   if_req      in   fetch request
//   ds_req      in   data request
//   last_owner  in   owner of the most recent grant (ignored in fixed mode)
//   winner      out  selected requester; only meaningful when a req is high
// -----------------------------------------------------------------------------
module mem_arb_pick_v1
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ds_req,
  input  owner_t last_owner,
  output owner_t winner
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    winner = OWN_DS;
    if (if_req && !ds_req) begin
      winner = OWN_IF;
    end else if (if_req && ds_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_owner == OWN_DS) ? OWN_IF : OWN_DS;
`else
      winner = OWN_DS;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority never looks at the history input.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter_v1.sv
// -----------------------------------------------------------------------------
// mem_arbiter_v1
// Shares the single memory port of the multicycle RV32 core between
// instruction fetch (IF) and data load/store (DS). One transaction in flight,
// fixed read latency MEM_LAT (1..15), one response pulse per transaction.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE (WAIT skipped when MEM_LAT == 1).
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking; otherwise
// DS has fixed priority and no pointer register exists).
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch accept, response pulse, read data
//   ds_req/ds_we/ds_be/ds_addr/ds_wdata   data request (held until ds_gnt)
//   ds_gnt/ds_rvalid/ds_rdata   data accept, response pulse, load data
//   mem_req/we/be/addr/wdata    one-cycle memory strobe and its payload
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_req
//   arb_error_vector      sticky error flags (bits 7:3 read 0)
// -----------------------------------------------------------------------------
module mem_arbiter_v1
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ds_req,
  input  logic              ds_we,
  input  logic [3:0]        ds_be,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [DATA_W-1:0] ds_wdata,
  output logic              ds_gnt,
  output logic              ds_rvalid,
  output logic [DATA_W-1:0] ds_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        arb_error_vector
);

  arb_state_t        state;
  logic [3:0]        lat_cnt;
  owner_t            owner;
  owner_t            winner;
  owner_t            last_owner;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [3:0]        cap_be;
  logic [DATA_W-1:0] cap_wdata;
  logic [ERR_W-1:0]  err;
  logic              accept;
  logic              resp;

  mem_arb_pick_v1 u_pick (
    .if_req     (if_req),
    .ds_req     (ds_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // Grants are combinational out of IDLE; qualifying with rst keeps them low
  // while reset is held even if a requester is already asserting.
  assign accept = (state == IDLE) && (if_req || ds_req) && rst;
  assign if_gnt = accept && (winner == OWN_IF);
  assign ds_gnt = accept && (winner == OWN_DS);

`ifdef MEM_ARB_RR_EN
  // Reset value OWN_IF makes the first tie go to DS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_owner <= OWN_IF;
    else if (accept) last_owner <= winner;
  end
`else
  assign last_owner = OWN_IF;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // The capture registers are reset as well: they feed mem_* directly and
  // must never leak X/stale payload after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= OWN_IF;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_wdata <= '0;
      err       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ISSUE;
            owner <= winner;
            if (winner == OWN_DS) begin
              cap_addr  <= ds_addr;
              cap_we    <= ds_we;
              cap_be    <= ds_be;
              cap_wdata <= ds_wdata;
              if (ds_be == 4'hF && misaligned(ds_addr[1:0]))
                err[ERR_DS_MISALIGN] <= 1'b1;
            end else begin
              // Fetches are always full-word reads.
              cap_addr  <= if_addr;
              cap_we    <= 1'b0;
              cap_be    <= 4'hF;
              cap_wdata <= '0;
              if (misaligned(if_addr[1:0]))
                err[ERR_IF_MISALIGN] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= 4'(MEM_LAT - 1);
          state   <= (MEM_LAT == 1) ? RESP : WAIT;
        end
        WAIT: begin
          // Counter holds the cycles left before data is valid.
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= RESP;
        end
        RESP: state <= IDLE;
        default: begin
          state        <= IDLE;
          err[ERR_FSM] <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req   = (state == ISSUE);
  assign mem_we    = mem_req & cap_we;
  assign mem_be    = mem_req ? cap_be    : '0;
  assign mem_addr  = mem_req ? cap_addr  : '0;
  assign mem_wdata = mem_req ? cap_wdata : '0;

  assign resp      = (state == RESP);
  assign if_rvalid = resp && (owner == OWN_IF);
  assign ds_rvalid = resp && (owner == OWN_DS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ds_rdata  = (ds_rvalid && !cap_we) ? mem_rdata : '0;

  assign arb_error_vector = {{(8 - ERR_W){1'b0}}, err};

endmodule

// File: tb/tb_mem_arbiter_v1.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_v1
// Directed bench for mem_arbiter_v1. Main instance uses MEM_LAT=2; two extra
// instances (MEM_LAT=1, MEM_LAT=15) share the inputs for latency checks.
// Memory read data is a cycle-stamped pattern so the response cycle is
// visible in the returned data.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_v1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, ds_req, ds_we;
  logic [31:0] if_addr, ds_addr, ds_wdata;
  logic [3:0]  ds_be;
  logic [15:0] cyc = 16'd0;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign mem_rdata = {16'hA500, cyc};

  logic        if_gnt, if_rvalid, ds_gnt, ds_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, ds_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [7:0]  err;

  logic        l1_if_gnt, l1_if_rvalid, l1_ds_gnt, l1_ds_rvalid, l1_mem_req, l1_mem_we;
  logic [31:0] l1_if_rdata, l1_ds_rdata, l1_mem_addr, l1_mem_wdata;
  logic [3:0]  l1_mem_be;
  logic [7:0]  l1_err;

  logic        l15_if_gnt, l15_if_rvalid, l15_ds_gnt, l15_ds_rvalid, l15_mem_req, l15_mem_we;
  logic [31:0] l15_if_rdata, l15_ds_rdata, l15_mem_addr, l15_mem_wdata;
  logic [3:0]  l15_mem_be;
  logic [7:0]  l15_err;

  mem_arbiter_v1 #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_be(ds_be), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_error_vector(err)
  );

  mem_arbiter_v1 #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_be(ds_be), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_gnt(l1_ds_gnt), .ds_rvalid(l1_ds_rvalid), .ds_rdata(l1_ds_rdata),
    .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_be(l1_mem_be), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata), .arb_error_vector(l1_err)
  );

  mem_arbiter_v1 #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(l15_if_gnt), .if_rvalid(l15_if_rvalid), .if_rdata(l15_if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_be(ds_be), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_gnt(l15_ds_gnt), .ds_rvalid(l15_ds_rvalid), .ds_rdata(l15_ds_rdata),
    .mem_req(l15_mem_req), .mem_we(l15_mem_we), .mem_be(l15_mem_be), .mem_addr(l15_mem_addr),
    .mem_wdata(l15_mem_wdata), .mem_rdata(mem_rdata), .arb_error_vector(l15_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; ds_req = 1'b0; ds_we = 1'b0; ds_be = 4'h0;
    if_addr = '0; ds_addr = '0; ds_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One full transaction on the MEM_LAT=2 instance, starting in an IDLE cycle.
  task automatic txn(input string tag, input bit is_ds, input bit we,
                     input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    logic [15:0] t0;
    logic [31:0] exp_rdata;
    if (is_ds) begin
      ds_req = 1'b1; ds_we = we; ds_be = be; ds_addr = addr; ds_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    sample();
    t0 = cyc;
    check({tag, "_gnt"},       is_ds ? ds_gnt : if_gnt, 32'd1);
    check({tag, "_other_gnt"}, is_ds ? if_gnt : ds_gnt, 32'd0);
    check({tag, "_mreq_T"},    mem_req, 32'd0);
    step();
    idle_inputs();
    sample();
    check({tag, "_mreq"},   mem_req, 32'd1);
    check({tag, "_mwe"},    mem_we, {31'd0, is_ds & we});
    check({tag, "_mbe"},    mem_be, is_ds ? {28'd0, be} : 32'hF);
    check({tag, "_maddr"},  mem_addr, addr);
    check({tag, "_mwdata"}, mem_wdata, (is_ds && we) ? wdata : 32'd0);
    step();
    sample();
    check({tag, "_mreq_off"},  mem_req, 32'd0);
    check({tag, "_maddr_off"}, mem_addr, 32'd0);
    check({tag, "_early_rv"},  is_ds ? ds_rvalid : if_rvalid, 32'd0);
    step();
    sample();
    exp_rdata = we ? 32'd0 : {16'hA500, t0 + 16'd3};
    check({tag, "_rvalid"},   is_ds ? ds_rvalid : if_rvalid, 32'd1);
    check({tag, "_rdata"},    is_ds ? ds_rdata : if_rdata, exp_rdata);
    check({tag, "_o_rvalid"}, is_ds ? if_rvalid : ds_rvalid, 32'd0);
    check({tag, "_o_rdata"},  is_ds ? if_rdata : ds_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, last;
    int g1_a, g2_a, m_a, r_a, g1_b, g2_b, m_b, r_b;

    // Reset state: requests asserted while rst is low must not be granted.
    idle_inputs();
    rst = 1'b0;
    step();
    if_req = 1'b1; ds_req = 1'b1;
    sample();
    check("rst_if_gnt", if_gnt, 0);
    check("rst_ds_gnt", ds_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rvalid", {if_rvalid, ds_rvalid}, 0);
    check("rst_err", err, 0);
    idle_inputs();
    step();
    rst = 1'b1;

    // Fetch at 0x100 and a partial store.
    txn("if_fetch", 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    step();
    txn("ds_store", 1'b1, 1'b1, 4'h3, 32'h0000_0204, 32'hDEAD_BEEF);
    check("err_clean", err, 8'h00);

    // Misaligned word load sets bit0; it stays set across good transactions.
    step();
    txn("ds_misld", 1'b1, 1'b0, 4'hF, 32'h0000_0302, 32'h0);
    check("err_ds_mis", err, 8'h01);
    step();
    txn("if_good", 1'b0, 1'b0, 4'hF, 32'h0000_0108, 32'h0);
    check("err_sticky1", err, 8'h01);
    step();
    txn("ds_halfmis", 1'b1, 1'b0, 4'h3, 32'h0000_0312, 32'h0);
    check("err_sticky2", err, 8'h01);
    step();
    txn("if_mis", 1'b0, 1'b0, 4'hF, 32'h0000_010A, 32'h0);
    check("err_if_mis", err, 8'h03);

    // Reset while a DS load is in WAIT: no response, outputs cleared.
    step();
    ds_req = 1'b1; ds_we = 1'b0; ds_be = 4'hF; ds_addr = 32'h0000_0140;
    sample();
    check("rw_ds_gnt", ds_gnt, 1);
    step();
    idle_inputs();
    sample();
    check("rw_issue", mem_req, 1);
    step();
    rst = 1'b0;
    sample();
    check("rw_rst_mreq", mem_req, 0);
    check("rw_rst_maddr", mem_addr, 0);
    check("rw_rst_rvalid", {if_rvalid, ds_rvalid}, 0);
    check("rw_rst_rdata", ds_rdata, 0);
    check("rw_rst_err", err, 0);
    step();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0110;
    sample();
    check("rw_no_late_rv", ds_rvalid, 0);
    check("rw_if_gnt", if_gnt, 1);
    step();
    idle_inputs();
    sample();
    check("rw_if_maddr", mem_addr, 32'h0000_0110);
    step();
    sample();
    check("rw_ds_rv_quiet", ds_rvalid, 0);
    step();
    sample();
    check("rw_if_rvalid", if_rvalid, 1);
    check("rw_ds_rvalid", ds_rvalid, 0);

    // Both requesters held high continuously.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0200;
    ds_req = 1'b1; ds_we = 1'b0; ds_be = 4'hF; ds_addr = 32'h0000_0400;
    ng = 0;
    last = -1;
    for (int c = 0; c < 16; c++) begin
      sample();
      if (if_gnt || ds_gnt) begin
`ifdef MEM_ARB_RR_EN
        check($sformatf("tie_g%0d_ds", ng), ds_gnt, (ng % 2 == 0) ? 1 : 0);
`else
        check($sformatf("tie_g%0d_ds", ng), ds_gnt, 1);
`endif
        check($sformatf("tie_g%0d_onehot", ng), if_gnt, !ds_gnt);
        if (ng > 0) check($sformatf("tie_g%0d_gap", ng), c - last, 4);
        last = c;
        ng++;
      end
      step();
    end
    check("tie_ngrants", ng, 4);
    idle_inputs();

    // Latency extremes: MEM_LAT=1 and MEM_LAT=15 with IF held high.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0500;
    g1_a = -100; g2_a = -100; m_a = -100; r_a = -100;
    g1_b = -100; g2_b = -100; m_b = -100; r_b = -100;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (l1_if_gnt) begin
        if (g1_a < 0) g1_a = c; else if (g2_a < 0) g2_a = c;
      end
      if (l1_mem_req && m_a < 0) m_a = c;
      if (l1_if_rvalid && r_a < 0) r_a = c;
      if (l15_if_gnt) begin
        if (g1_b < 0) g1_b = c; else if (g2_b < 0) g2_b = c;
      end
      if (l15_mem_req && m_b < 0) m_b = c;
      if (l15_if_rvalid && r_b < 0) r_b = c;
      step();
    end
    idle_inputs();
    check("l1_first_gnt", g1_a, 0);
    check("l1_req_lat", m_a - g1_a, 1);
    check("l1_rsp_lat", r_a - m_a, 1);
    check("l1_gnt_gap", g2_a - g1_a, 3);
    check("l15_first_gnt", g1_b, 0);
    check("l15_req_lat", m_b - g1_b, 1);
    check("l15_rsp_lat", r_b - m_b, 15);
    check("l15_gnt_gap", g2_b - g1_b, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
